weight_pingpong_buffer: RTL and testbench

Double-buffered weight memory between the weight loader and the convolution array. Narrow lanes are written into one half, packed into wide read words, and read by the array from the other half. The halves swap through a fill/release handshake, so the next tile's weights load while the current tile computes. This block is the parametrised successor of the single-half 36-in/144-out DRM weight array. It adds configurable bank count, lane width and pack ratio, auto-incrementing write addressing, tile-length tracking and flow control.

---
 rtl/weight_buf_pkg.sv | 36 +++
 rtl/weight_bank_mem.sv | 65 ++++++
 rtl/weight_pingpong_buffer.sv | 120 ++++++++++++
 tb/tb_weight_pingpong_buffer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/weight_buf_pkg.sv
// Shared widths and slice helpers for the ping-pong weight buffer.
// The localparams below describe the default configuration.
package weight_buf_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = 1; v < value; v = v * 2) r++;
        return r;
    endfunction

    localparam int DEF_BANK_NUM   = 9;
    localparam int DEF_LANE_WIDTH = 36;
    localparam int DEF_RD_RATIO   = 4;
    localparam int DEF_RD_DEPTH   = 256;

    localparam int WR_DEPTH      = DEF_RD_DEPTH * DEF_RD_RATIO;
    localparam int WR_ADDR_WIDTH = clog2(WR_DEPTH);
    localparam int RD_WIDTH      = DEF_LANE_WIDTH * DEF_RD_RATIO;

    // LSB of bank b's write lane inside the flat wr_data bus.
    function automatic int lane_lsb(input int bank, input int lane_width);
        return bank * lane_width;
    endfunction

    // LSB of bank b's read word inside the flat rd_data bus.
    function automatic int word_lsb(input int bank, input int rd_width);
        return bank * rd_width;
    endfunction

    // LSB of sub-slot s inside one bank's read word.
    function automatic int slot_lsb(input int slot, input int lane_width);
        return slot * lane_width;
    endfunction

endpackage

// File: rtl/weight_bank_mem.sv
// One bank: narrow lane writes, wide word reads, both halves in one array.
// Each sub-slot is its own narrow array so writes never need read-modify-write.
module weight_bank_mem
    import weight_buf_pkg::*;
#(
    parameter int LANE_WIDTH    = 36,
    parameter int RD_RATIO      = 4,
    parameter int RD_DEPTH      = 256,
    parameter int RD_ADDR_WIDTH = 8
) (
    input  logic                                            clk,
    input  logic                                            rstn,
    input  logic                                            wr_en,
    input  logic                                            wr_half,
    input  logic [RD_ADDR_WIDTH+clog2(RD_RATIO)-1:0]        wr_beat,
    input  logic [LANE_WIDTH-1:0]                           wr_lane,
    input  logic                                            rd_en,
    input  logic                                            rd_half,
    input  logic [RD_ADDR_WIDTH-1:0]                        rd_word,
    output logic [LANE_WIDTH*RD_RATIO-1:0]                  rd_data
);

    localparam int SLOT_W        = clog2(RD_RATIO);
    localparam int SW            = (SLOT_W > 0) ? SLOT_W : 1;
    localparam int WR_ADDR_WIDTH = RD_ADDR_WIDTH + SLOT_W;

    logic [RD_ADDR_WIDTH:0] wr_idx;
    logic [RD_ADDR_WIDTH:0] rd_idx;
    logic [SW-1:0]          wr_slot;

    // Half select is the MSB of both memory addresses.
    assign wr_idx = {wr_half, wr_beat[WR_ADDR_WIDTH-1 -: RD_ADDR_WIDTH]};
    assign rd_idx = {rd_half, rd_word};

    generate
        if (SLOT_W > 0) begin : g_slot
            assign wr_slot = wr_beat[SW-1:0];
        end else begin : g_noslot
            assign wr_slot = '0;
        end
    endgenerate

    genvar s;
    generate
        for (s = 0; s < RD_RATIO; s++) begin : g_sub
            logic [LANE_WIDTH-1:0] mem [2*RD_DEPTH];
            logic [LANE_WIDTH-1:0] slot_q;

            always_ff @(posedge clk) begin
                if (wr_en && (wr_slot == SW'(s)))
                    mem[wr_idx] <= wr_lane;
            end

            always_ff @(posedge clk) begin
                if (!rstn)
                    slot_q <= '0;
                else if (rd_en)
                    slot_q <= mem[rd_idx];
            end

            assign rd_data[slot_lsb(s, LANE_WIDTH) +: LANE_WIDTH] = slot_q;
        end
    endgenerate

endmodule

// File: rtl/weight_pingpong_buffer.sv
// Double-buffered weight memory: the loader fills one half while the
// convolution array reads the other; halves swap via completion/release.
module weight_pingpong_buffer
    import weight_buf_pkg::*;
#(
    parameter int BANK_NUM      = 9,
    parameter int LANE_WIDTH    = 36,
    parameter int RD_RATIO      = 4,
    parameter int RD_DEPTH      = 256,
    parameter int RD_ADDR_WIDTH = $clog2(RD_DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [BANK_NUM*LANE_WIDTH-1:0]         wr_data,
    input  logic                                   wr_valid,
    input  logic                                   wr_last,
    output logic                                   wr_ready,
    input  logic                                   rd_en,
    input  logic [RD_ADDR_WIDTH-1:0]               rd_addr,
    output logic [BANK_NUM*LANE_WIDTH*RD_RATIO-1:0] rd_data,
    output logic                                   rd_valid,
    output logic                                   weight_ready,
    output logic [RD_ADDR_WIDTH:0]                 rd_words,
    input  logic                                   rd_release,
    output logic                                   err
);

    localparam int SLOT_W        = clog2(RD_RATIO);
    localparam int WR_ADDR_WIDTH = RD_ADDR_WIDTH + SLOT_W;
    localparam int WR_LAST_BEAT  = RD_DEPTH * RD_RATIO - 1;
    localparam int RD_WIDTH      = LANE_WIDTH * RD_RATIO;

    logic [1:0]               full_q;
    logic [1:0]               full_d;
    logic                     wsel_q;
    logic                     rsel_q;
    logic [WR_ADDR_WIDTH-1:0] waddr_q;
    logic [RD_ADDR_WIDTH:0]   len_q [2];
    logic                     err_q;
    logic                     vld_p1;

    logic                     wr_fire;
    logic                     wr_done;
    logic [RD_ADDR_WIDTH:0]   tile_words;
    logic                     rd_fire;
    logic                     rel_ok;
    logic                     rel_bad;

    assign wr_ready = ~full_q[wsel_q];
    assign wr_fire  = wr_valid & wr_ready;
    assign wr_done  = wr_fire & (wr_last | (waddr_q == WR_ADDR_WIDTH'(WR_LAST_BEAT)));
    assign rd_fire  = rd_en & full_q[rsel_q];
    assign rel_ok   = rd_release & full_q[rsel_q];
    assign rel_bad  = rd_release & ~full_q[rsel_q];

    // ceil((waddr+1)/RD_RATIO) is the word index of the last beat plus one.
    assign tile_words = {1'b0, waddr_q[WR_ADDR_WIDTH-1 -: RD_ADDR_WIDTH]} + (RD_ADDR_WIDTH+1)'(1);

    // Completion and release never target the same half, so both may apply.
    always_comb begin
        full_d = full_q;
        if (wr_done) full_d[wsel_q] = 1'b1;
        if (rel_ok)  full_d[rsel_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            full_q   <= '0;
            wsel_q   <= 1'b0;
            rsel_q   <= 1'b0;
            waddr_q  <= '0;
            len_q[0] <= '0;
            len_q[1] <= '0;
            err_q    <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            full_q <= full_d;
            if (wr_done) begin
                len_q[wsel_q] <= tile_words;
                wsel_q        <= ~wsel_q;
                waddr_q       <= '0;
            end else if (wr_fire) begin
                waddr_q <= waddr_q + WR_ADDR_WIDTH'(1);
            end
            if (rel_ok)  rsel_q <= ~rsel_q;
            if (rel_bad) err_q  <= 1'b1;
            vld_p1 <= rd_fire;
        end
    end

    assign weight_ready = full_q[rsel_q];
    assign rd_words     = len_q[rsel_q];
    assign rd_valid     = vld_p1;
    assign err          = err_q;

    // Bank read registers hold when no read is accepted and clear on reset.
    genvar b;
    generate
        for (b = 0; b < BANK_NUM; b++) begin : g_bank
            weight_bank_mem #(
                .LANE_WIDTH    (LANE_WIDTH),
                .RD_RATIO      (RD_RATIO),
                .RD_DEPTH      (RD_DEPTH),
                .RD_ADDR_WIDTH (RD_ADDR_WIDTH)
            ) u_bank (
                .clk     (clk),
                .rstn    (rstn),
                .wr_en   (wr_fire),
                .wr_half (wsel_q),
                .wr_beat (waddr_q),
                .wr_lane (wr_data[lane_lsb(b, LANE_WIDTH) +: LANE_WIDTH]),
                .rd_en   (rd_fire),
                .rd_half (rsel_q),
                .rd_word (rd_addr),
                .rd_data (rd_data[word_lsb(b, RD_WIDTH) +: RD_WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Directed bench for weight_pingpong_buffer at default parameters.
module tb_weight_pingpong_buffer;

    localparam int BN  = 9;
    localparam int LW  = 36;
    localparam int RR  = 4;
    localparam int RD  = 256;
    localparam int RAW = 8;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [BN*LW-1:0]     wr_data;
    logic                 wr_valid;
    logic                 wr_last;
    logic                 wr_ready;
    logic                 rd_en;
    logic [RAW-1:0]       rd_addr;
    logic [BN*LW*RR-1:0]  rd_data;
    logic                 rd_valid;
    logic                 weight_ready;
    logic [RAW:0]         rd_words;
    logic                 rd_release;
    logic                 err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    weight_pingpong_buffer #(
        .BANK_NUM   (BN),
        .LANE_WIDTH (LW),
        .RD_RATIO   (RR),
        .RD_DEPTH   (RD)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_last      (wr_last),
        .wr_ready     (wr_ready),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .weight_ready (weight_ready),
        .rd_words     (rd_words),
        .rd_release   (rd_release),
        .err          (err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lane b of beat k = {b[3:0], k[9:0]} zero-extended.
    function automatic logic [LW-1:0] beat_val(input int b, input int k);
        logic [3:0] bb;
        logic [9:0] kk;
        bb = 4'(b);
        kk = 10'(k);
        return {22'd0, bb, kk};
    endfunction

    function automatic logic [LW-1:0] slot_of(input int b, input int s);
        return rd_data[(b*RR+s)*LW +: LW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tile(input int n, input int off, input bit last, input bit rel_on_last);
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < BN; b++) wr_data[b*LW +: LW] = beat_val(b, k + off);
            wr_valid   = 1'b1;
            wr_last    = last && (k == n - 1);
            rd_release = rel_on_last && (k == n - 1);
            tick();
        end
        wr_valid   = 1'b0;
        wr_last    = 1'b0;
        rd_release = 1'b0;
    endtask

    task automatic read_word(input int addr);
        rd_en   = 1'b1;
        rd_addr = RAW'(addr);
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic check_word(input string tag, input int first_beat, input int nslots);
        for (int b = 0; b < BN; b++)
            for (int s = 0; s < nslots; s++)
                check_eq($sformatf("%s_b%0d_s%0d", tag, b, s),
                         64'(slot_of(b, s)), 64'(beat_val(b, first_beat + s)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_wr_ready"},     64'(wr_ready),     64'd1);
        check_eq({tag, "_weight_ready"}, 64'(weight_ready), 64'd0);
        check_eq({tag, "_rd_words"},     64'(rd_words),     64'd0);
        check_eq({tag, "_rd_valid"},     64'(rd_valid),     64'd0);
        check_eq({tag, "_rd_data_nz"},   64'(|rd_data),     64'd0);
        check_eq({tag, "_err"},          64'(err),          64'd0);
    endtask

    initial begin
        rstn = 1'b0; wr_data = '0; wr_valid = 1'b0; wr_last = 1'b0;
        rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
        tick(); tick();
        check_reset_outputs("reset");
        rstn = 1'b1;

        read_word(0);
        check_eq("empty_read_vld", 64'(rd_valid), 64'd0);

        // Full 1024-beat tile, completed by the beat counter reaching its end
        write_tile(1024, 0, 1'b0, 1'b0);
        check_eq("full_weight_ready", 64'(weight_ready), 64'd1);
        check_eq("full_rd_words",     64'(rd_words),     64'd256);
        check_eq("full_wr_ready",     64'(wr_ready),     64'd1);

        read_word(5);
        check_eq("full_w5_vld", 64'(rd_valid), 64'd1);
        check_word("full_w5", 20, RR);
        tick();
        check_eq("vld_pulse",  64'(rd_valid),      64'd0);
        check_eq("data_holds", 64'(slot_of(0, 0)), 64'(beat_val(0, 20)));

        rd_en = 1'b1; rd_addr = 8'd0;
        tick();
        check_eq("pipe0_vld",  64'(rd_valid),      64'd1);
        check_eq("pipe0_data", 64'(slot_of(0, 0)), 64'(beat_val(0, 0)));
        rd_addr = 8'd255;
        tick();
        rd_en = 1'b0;
        check_eq("pipe1_vld",  64'(rd_valid),      64'd1);
        check_eq("pipe1_data", 64'(slot_of(0, 3)), 64'(beat_val(0, 1023)));

        // Partial tile into half 1 while half 0 is still held
        write_tile(10, 100, 1'b1, 1'b0);
        check_eq("pp_wr_ready_low", 64'(wr_ready),     64'd0);
        check_eq("pp_rd_words_old", 64'(rd_words),     64'd256);
        check_eq("pp_weight_ready", 64'(weight_ready), 64'd1);
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        check_eq("pp_wr_ready_high", 64'(wr_ready),     64'd1);
        check_eq("pp_weight_ready1", 64'(weight_ready), 64'd1);
        check_eq("part_rd_words",    64'(rd_words),     64'd3);
        check_eq("pp_err",           64'(err),          64'd0);
        read_word(0); check_word("part_w0", 100, RR);
        read_word(1); check_word("part_w1", 104, RR);
        read_word(2); check_word("part_w2", 108, 2);

        // Completion of half 0 in the same cycle as release of half 1
        write_tile(4, 200, 1'b1, 1'b1);
        check_eq("sim_weight_ready", 64'(weight_ready), 64'd1);
        check_eq("sim_rd_words",     64'(rd_words),     64'd1);
        check_eq("sim_wr_ready",     64'(wr_ready),     64'd1);
        check_eq("sim_err",          64'(err),          64'd0);
        read_word(0); check_word("sim_w0", 200, RR);

        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        check_eq("rel_empty_ready", 64'(weight_ready), 64'd0);
        read_word(1);
        check_eq("empty2_vld",  64'(rd_valid),      64'd0);
        check_eq("empty2_hold", 64'(slot_of(0, 0)), 64'(beat_val(0, 200)));

        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        check_eq("err_set", 64'(err), 64'd1);
        tick(); tick(); tick();
        check_eq("err_sticky", 64'(err), 64'd1);

        // Reset in the middle of a fill, then a short tile
        write_tile(300, 500, 1'b0, 1'b0);
        rstn = 1'b0;
        tick();
        check_reset_outputs("midreset");
        rstn = 1'b1;
        write_tile(4, 400, 1'b1, 1'b0);
        check_eq("post_weight_ready", 64'(weight_ready), 64'd1);
        check_eq("post_rd_words",     64'(rd_words),     64'd1);
        read_word(0);
        check_eq("post_vld", 64'(rd_valid), 64'd1);
        check_word("post_w0", 400, RR);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
